// File: rtl/ibutterfly_pipe.sv
// Inverse radix-2 butterfly: recovers A = (X+Y)/2 and B = ((X-Y)/2)*conj(W)
// through a 3-stage valid/ready pipeline with saturation and a sticky overflow flag.
module ibutterfly_pipe #(
    parameter int WORD_SZ  = 32,
    parameter int WORD_MID = 16,
    parameter int TW_FRAC  = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WORD_SZ-1:0] i_X,
    input  logic [WORD_SZ-1:0] i_Y,
    input  logic [WORD_SZ-1:0] i_twiddle,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WORD_SZ-1:0] o_A,
    output logic [WORD_SZ-1:0] o_B,
    output logic               o_ovf
);

    localparam int CW = WORD_MID;
    localparam int PW = 2 * CW;
    localparam int SW = PW + 1;

    // Handshake: o_ready = en. When en = 0 every stage freezes, bubbles
    // included; an input transfer is i_valid & o_ready, an output transfer
    // is o_valid & i_ready.
    logic en;

    logic                 v1_q, v2_q, v3_q;
    logic signed [CW-1:0] a1r_q, a1i_q, d1r_q, d1i_q, w1r_q, w1i_q;
    logic signed [CW-1:0] a1r_d, a1i_d, d1r_d, d1i_d;
    logic [WORD_SZ-1:0]   a2_q;
    logic signed [SW-1:0] br_q, bi_q, br_d, bi_d;
    logic [WORD_SZ-1:0]   a3_q, b3_q, b3_d;
    logic                 ovf_q, sat_any;

    assign en      = ~v3_q | i_ready;
    assign o_ready = en;
    assign o_valid = v3_q;
    assign o_A     = a3_q;
    assign o_B     = b3_q;
    assign o_ovf   = ovf_q;

    // S1: 17-bit sum/difference, keep bits [16:1] = arithmetic shift by one.
    logic [CW:0] sum_r, sum_i, dif_r, dif_i;

    always_comb begin
        sum_r = {i_X[WORD_SZ-1], i_X[WORD_SZ-1:WORD_MID]} + {i_Y[WORD_SZ-1], i_Y[WORD_SZ-1:WORD_MID]};
        sum_i = {i_X[WORD_MID-1], i_X[WORD_MID-1:0]} + {i_Y[WORD_MID-1], i_Y[WORD_MID-1:0]};
        dif_r = {i_X[WORD_SZ-1], i_X[WORD_SZ-1:WORD_MID]} - {i_Y[WORD_SZ-1], i_Y[WORD_SZ-1:WORD_MID]};
        dif_i = {i_X[WORD_MID-1], i_X[WORD_MID-1:0]} - {i_Y[WORD_MID-1], i_Y[WORD_MID-1:0]};
        a1r_d = sum_r[CW:1];
        a1i_d = sum_i[CW:1];
        d1r_d = dif_r[CW:1];
        d1i_d = dif_i[CW:1];
    end

    // S2: multiply by conj(W).
    logic signed [PW-1:0] dr_x, di_x, wr_x, wi_x;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;

    always_comb begin
        dr_x = PW'(d1r_q);
        di_x = PW'(d1i_q);
        wr_x = PW'(w1r_q);
        wi_x = PW'(w1i_q);
        p_rr = dr_x * wr_x;
        p_ii = di_x * wi_x;
        p_ir = di_x * wr_x;
        p_ri = dr_x * wi_x;
        br_d = SW'(p_rr) + SW'(p_ii);
        bi_d = SW'(p_ir) - SW'(p_ri);
    end

    // Returns {saturated, value} for a value already scaled down by TW_FRAC.
    function automatic logic [CW:0] sat_comp(input logic signed [SW-1:0] v);
        logic hi_ones;
        logic hi_zero;
        hi_ones = &v[SW-1:CW-1];
        hi_zero = ~|v[SW-1:CW-1];
        if (hi_ones || hi_zero) begin
            sat_comp = {1'b0, v[CW-1:0]};
        end else if (v[SW-1]) begin
            sat_comp = {1'b1, 1'b1, {(CW-1){1'b0}}};
        end else begin
            sat_comp = {1'b1, 1'b0, {(CW-1){1'b1}}};
        end
    endfunction

    // S3: scale and saturate.
    logic signed [SW-1:0] br_sh, bi_sh;
    logic [CW:0]          sat_r, sat_i;

    always_comb begin
        br_sh   = br_q >>> TW_FRAC;
        bi_sh   = bi_q >>> TW_FRAC;
        sat_r   = sat_comp(br_sh);
        sat_i   = sat_comp(bi_sh);
        b3_d    = {sat_r[CW-1:0], sat_i[CW-1:0]};
        sat_any = sat_r[CW] | sat_i[CW];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            a1r_q <= '0;
            a1i_q <= '0;
            d1r_q <= '0;
            d1i_q <= '0;
            w1r_q <= '0;
            w1i_q <= '0;
            a2_q  <= '0;
            br_q  <= '0;
            bi_q  <= '0;
            a3_q  <= '0;
            b3_q  <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            v1_q <= i_valid;
            if (i_valid) begin
                a1r_q <= a1r_d;
                a1i_q <= a1i_d;
                d1r_q <= d1r_d;
                d1i_q <= d1i_d;
                w1r_q <= i_twiddle[WORD_SZ-1:WORD_MID];
                w1i_q <= i_twiddle[WORD_MID-1:0];
            end
            v2_q <= v1_q;
            a2_q <= {a1r_q, a1i_q};
            br_q <= br_d;
            bi_q <= bi_d;
            v3_q <= v2_q;
            a3_q <= a2_q;
            b3_q <= b3_d;
            // Only a real transaction entering S3 may raise the sticky flag.
            if (v2_q && sat_any) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibutterfly_pipe.sv
// Bench for ibutterfly_pipe: directed vectors plus random stream with random
// backpressure, checked against a plain-arithmetic model through a queue.
module tb_ibutterfly_pipe;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_X = '0, i_Y = '0, i_twiddle = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_A, o_B;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;

    // {sat, A, B}
    logic [64:0] exp_q[$];
    bit          ovf_model = 1'b0;
    bit          rdy_random = 1'b0;
    bit          stall_q = 1'b0;
    logic [31:0] hold_a, hold_b;

    ibutterfly_pipe #(.WORD_SZ(32), .WORD_MID(16), .TW_FRAC(6)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_X(i_X), .i_Y(i_Y), .i_twiddle(i_twiddle), .o_valid(o_valid),
        .i_ready(i_ready), .o_A(o_A), .o_B(o_B), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    function automatic longint floor_div(input longint v, input longint d);
        longint q;
        q = v / d;
        if ((v % d != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input longint v, inout bit sat);
        if (v > 32767) begin sat = 1'b1; return 32767; end
        if (v < -32768) begin sat = 1'b1; return -32768; end
        return int'(v);
    endfunction

    function automatic logic [64:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] w);
        int xr, xi, yr, yi, wr, wi, ar, ai, dr, di, brs, bis;
        longint br, bi;
        bit sat;
        logic [31:0] a, b;
        xr = $signed(x[31:16]); xi = $signed(x[15:0]);
        yr = $signed(y[31:16]); yi = $signed(y[15:0]);
        wr = $signed(w[31:16]); wi = $signed(w[15:0]);
        ar = int'(floor_div(xr + yr, 2));
        ai = int'(floor_div(xi + yi, 2));
        dr = int'(floor_div(xr - yr, 2));
        di = int'(floor_div(xi - yi, 2));
        br = longint'(dr) * wr + longint'(di) * wi;
        bi = longint'(di) * wr - longint'(dr) * wi;
        sat = 1'b0;
        brs = clamp16(floor_div(br, 64), sat);
        bis = clamp16(floor_div(bi, 64), sat);
        a = {ar[15:0], ai[15:0]};
        b = {brs[15:0], bis[15:0]};
        return {sat, a, b};
    endfunction

    task automatic pin(input string name, input logic [64:0] got, input logic [64:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: model got %h required %h", name, got, req);
        end
    endtask

    // Compare process: output transfers against the model queue, and stall rules.
    always @(negedge i_clk) begin
        logic [64:0] e;
        if (i_reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (!(o_valid === 1'b1 && o_A === hold_a && o_B === hold_b)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b A=%h B=%h required v=1 A=%h B=%h",
                             o_valid, o_A, o_B, hold_a, hold_b);
                end
            end
            if (o_valid && !i_ready) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure_ready: got o_ready=%b required 0", o_ready);
                end
            end
            stall_q = o_valid && !i_ready;
            hold_a = o_A;
            hold_b = o_B;
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output: got A=%h B=%h required no output", o_A, o_B);
                end else begin
                    e = exp_q.pop_front();
                    if (o_A !== e[63:32] || o_B !== e[31:0]) begin
                        errors++;
                        $display("FAIL data: got A=%h B=%h required A=%h B=%h",
                                 o_A, o_B, e[63:32], e[31:0]);
                    end
                    ovf_model = ovf_model | e[64];
                    checks++;
                    if (o_ovf !== ovf_model) begin
                        errors++;
                        $display("FAIL ovf: got %b required %b", o_ovf, ovf_model);
                    end
                end
            end
        end
    end

    always @(posedge i_clk) begin
        #1;
        if (rdy_random) i_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] w);
        logic [64:0] e;
        bit acc;
        int n;
        e = model(x, y, w);
        i_X = x; i_Y = y; i_twiddle = w; i_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge i_clk); #1;
            acc = o_ready;
            if (acc) exp_q.push_back(e);
            @(posedge i_clk); #1;
            n++;
        end
        i_valid = 1'b0;
        i_X = $urandom; i_Y = $urandom; i_twiddle = $urandom;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no acceptance in 200 cycles required acceptance");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic drain();
        int n;
        rdy_random = 1'b0;
        i_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin idle(1); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results required 0", exp_q.size());
        end
    endtask

    task automatic check_reset_state(input string name);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_A !== 32'h0 || o_B !== 32'h0 || o_ovf !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got v=%b A=%h B=%h ovf=%b rdy=%b required v=0 A=0 B=0 ovf=0 rdy=1",
                     name, o_valid, o_A, o_B, o_ovf, o_ready);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        exp_q.delete();
        ovf_model = 1'b0;
    endtask

    function automatic logic [31:0] small_word();
        int r, i;
        r = $urandom_range(0, 2000) - 1000;
        i = $urandom_range(0, 2000) - 1000;
        return {r[15:0], i[15:0]};
    endfunction

    function automatic logic [31:0] rand_tw();
        int r, i;
        if ($urandom_range(0, 3) == 0) return $urandom;
        r = $urandom_range(0, 128) - 64;
        i = $urandom_range(0, 128) - 64;
        return {r[15:0], i[15:0]};
    endfunction

    initial begin
        pin("model_identity", model(32'h0064_0014, 32'h003C_FFD8, 32'h0040_0000),
            {1'b0, 32'h0050_FFF6, 32'h0014_001E});
        pin("model_minus_j", model(32'h0064_0014, 32'h003C_FFD8, 32'h0000_FFC0),
            {1'b0, 32'h0050_FFF6, 32'hFFE2_0014});
        pin("model_rounding", model(32'h0003_FFFD, 32'h0, 32'h0040_0000),
            {1'b0, 32'h0001_FFFE, 32'h0001_FFFE});
        pin("model_saturation", model(32'h7FFF_7FFF, 32'h8000_8000, 32'h7FFF_7FFF),
            {1'b1, 32'hFFFF_FFFF, 32'h7FFF_0000});

        idle(2);
        i_reset = 1'b0;
        check_reset_state("reset_state");

        // Directed test-plan vectors.
        send(32'h0064_0014, 32'h003C_FFD8, 32'h0040_0000);
        send(32'h0064_0014, 32'h003C_FFD8, 32'h0000_FFC0);
        send(32'h0003_FFFD, 32'h0000_0000, 32'h0040_0000);
        drain();

        // Saturation followed by 10 clean transfers; sticky flag checked on each.
        send(32'h7FFF_7FFF, 32'h8000_8000, 32'h7FFF_7FFF);
        for (int k = 0; k < 10; k++) send(small_word(), small_word(), 32'h0040_0000);
        drain();
        checks++;
        if (o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b required 1", o_ovf);
        end

        // Six back-to-back vectors, i_ready low from cycle 2 to cycle 5.
        fork
            for (int k = 0; k < 6; k++) send($urandom, $urandom, rand_tw());
            begin
                i_ready = 1'b1;
                idle(1);
                i_ready = 1'b0;
                idle(4);
                i_ready = 1'b1;
            end
        join
        drain();

        // Randomized stream with random gaps and random backpressure.
        do_reset();
        rdy_random = 1'b1;
        for (int k = 0; k < 200; k++) begin
            send($urandom, $urandom, rand_tw());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Reset mid-stream: two accepted vectors must vanish.
        send($urandom, $urandom, rand_tw());
        send($urandom, $urandom, rand_tw());
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        exp_q.delete();
        ovf_model = 1'b0;
        check_reset_state("reset_midstream");
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset: got o_valid=%b required 0", o_valid);
            end
            @(posedge i_clk); #1;
        end

        send(32'h0064_0014, 32'h003C_FFD8, 32'h0040_0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibutterfly_pipe.md
# ibutterfly_pipe

Pipelined inverse radix-2 butterfly for the FFT datapath. It undoes one forward butterfly stage: given the stage outputs X = A + W·B and Y = A − W·B plus the stage twiddle W, it recovers A = (X+Y)/2 and B = ((X−Y)/2)·conj(W). It uses the same packed complex word and twiddle fixed-point format as the forward butterfly, and adds a 3-stage valid/ready pipeline, saturation and a sticky overflow flag. It sits in the IFFT path between the stage memory reader and the stage memory writer.

## Interface
- WORD_SZ, 32: packed complex word width. Real part is in [WORD_SZ-1:WORD_MID], imaginary part in [WORD_MID-1:0].
- WORD_MID, 16: component width.
- TW_FRAC, 6: twiddle fractional bits. 1.0 = 64.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  input transfer qualifier
- o_ready  out  1  block accepts input this cycle
- i_X  in  32  forward-stage upper output, packed complex, signed 16-bit components
- i_Y  in  32  forward-stage lower output, same format
- i_twiddle  in  32  W, packed complex, signed, TW_FRAC fractional bits
- o_valid  out  1  o_A and o_B are valid
- i_ready  in  1  downstream accepts output
- o_A  out  32  recovered A
- o_B  out  32  recovered B
- o_ovf  out  1  sticky flag: some B component saturated since reset

## Operation
- All arithmetic is signed two's complement.
- Pipeline advance enable: en = ~o_valid | i_ready. Every stage register loads only when en = 1. o_ready = en (combinational).
- An input transfer happens when i_valid & o_ready. An output transfer happens when o_valid & i_ready.
- **S1** (registered on transfer):
  - sum = X + Y and diff = X − Y, per component, 17-bit.
  - Each result is shifted right arithmetically by 1 (rounds toward −inf) and kept as 16 bits. These always fit; no saturation.
  - A = halved sum. D = halved diff.
  - W is registered alongside.
- **S2**: 32-bit products into 33-bit sums.
  - Br = Dr·Wr + Di·Wi
  - Bi = Di·Wr − Dr·Wi
- **S3**: each of Br and Bi is shifted right arithmetically by TW_FRAC, then saturated to [−32768, 32767]. If either component saturates on a transfer into S3, o_ovf is set to 1.
  - o_A = {Ar, Ai}. o_B = {Br_sat, Bi_sat}.
- Stage valid bits v1, v2, v3 move with en. o_valid = v3.
- Bubbles are not collapsed. When en = 0, the whole pipe freezes, including empty stages.
- o_ovf stays at 1 until i_reset.

## Timing
- Reset (synchronous, i_reset = 1 at a rising edge): v1 = v2 = v3 = 0, o_valid = 0, o_A = 0, o_B = 0, o_ovf = 0. Stage data registers are cleared to 0. During reset, o_ready = 1 (follows en).
- Reset while transactions are in flight discards them. No output appears for them after reset is released.
- Latency: an input accepted at edge n appears on o_A/o_B with o_valid = 1 after edge n+2. It is visible in the cycle after edge n+2, i.e. 3 register stages.
- Throughput: one transfer per cycle while i_ready = 1.
- Backpressure: if o_valid = 1 and i_ready = 0, then o_ready = 0 in the same cycle. o_A, o_B and o_valid hold stable until i_ready = 1.
- Simultaneous output and input transfer in the same cycle is allowed. The pipe shifts by one.
- i_X, i_Y and i_twiddle are sampled only on input transfer cycles. Their values at other times are don't-care.
- Output order equals input order. No drop, no duplication.

## Test plan
- **Identity twiddle:** X = 0x0064_0014 (100, 20), Y = 0x003C_FFD8 (60, −40), W = 0x0040_0000. After 3 cycles: o_A = 0x0050_FFF6 (80, −10), o_B = 0x0014_001E (20, 30), o_ovf = 0.
- **−j twiddle:** same X and Y, W = 0x0000_FFC0. Required: o_B = 0xFFE2_0014 (−30, 20), o_A unchanged from the identity case.
- **Rounding:** X = 0x0003_FFFD (3, −3), Y = 0, W = 1.0. Required: o_A = 0x0001_FFFE (1, −2), o_B = 0x0001_FFFE.
- **Saturation:** X = 0x7FFF_7FFF, Y = 0x8000_8000, W = 0x7FFF_7FFF. Required: o_B real = 0x7FFF, o_ovf = 1 and still 1 after 10 more clean transfers.
- **Backpressure:** stream 6 back-to-back vectors with i_ready held 0 from the 2nd to the 5th cycle.
  - Required: o_ready = 0 while o_valid = 1 and i_ready = 0.
  - o_A/o_B stable while stalled.
  - All 6 results delivered in order, bit-exact against a reference model.
- **Reset mid-stream:** accept 2 vectors, assert i_reset for one cycle. Required: o_valid = 0, o_A = o_B = 0, o_ovf = 0 on the next cycle, and no stale outputs afterwards.
